// File: rtl/fish_pkg.sv
// Shared types and constants for the fish sprite motion block.
package fish_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SWIM = 2'd1,
    ST_LIFT = 2'd2
  } fish_state_e;

  localparam logic [1:0]  WAY_LEFT     = 2'd0;
  localparam logic [1:0]  WAY_RIGHT    = 2'd1;
  localparam logic [1:0]  WAY_UP       = 2'd2;
  localparam logic [10:0] FISH_W       = 11'd40;
  localparam logic [10:0] FISH_H       = 11'd33;
  localparam logic [9:0]  SPAWN_H_LEFT = 10'd680;

  // Inclusive window compare on 11-bit values
  function automatic logic in_range11(input logic [10:0] val,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
    return (lo <= val) && (val <= hi);
  endfunction

endpackage

// File: rtl/fish_hit_detect.sv
// Combinational hook-versus-swimming-fish window compare.
// Columns are h-40 .. h-1 in 11 bits, so a fish with h<40 has a wrapped lower bound and never hits.
module fish_hit_detect
  import fish_pkg::*;
(
  input  logic [9:0] fish_h,
  input  logic [9:0] fish_v,
  input  logic [9:0] hook_h,
  input  logic [9:0] hook_v,
  input  logic       hook_down,
  output logic       hit
);

  logic [10:0] col_lo_s;
  logic [10:0] col_hi_s;
  logic [10:0] row_lo_s;
  logic [10:0] row_hi_s;

  // Sprite window bounds and the hit decision
  always_comb begin
    col_lo_s = {1'b0, fish_h} - FISH_W;
    col_hi_s = {1'b0, fish_h} - 11'd1;
    row_lo_s = {1'b0, fish_v};
    row_hi_s = {1'b0, fish_v} + (FISH_H - 11'd1);
    hit      = hook_down
             && in_range11({1'b0, hook_h}, col_lo_s, col_hi_s)
             && in_range11({1'b0, hook_v}, row_lo_s, row_hi_s);
  end

endmodule

// File: rtl/fish_motion.sv
// Fish sprite motion: IDLE -> SWIM (horizontal) -> LIFT (hooked, rising) with caught/escaped pulses.
// Optional vertical wobble while swimming is enabled with `define FISH_MOTION_WOBBLE_EN.
module fish_motion
  import fish_pkg::*;
#(
  parameter int unsigned SPEED      = 32'd2,
  parameter int unsigned RISE_SPEED = 32'd3,
  parameter int unsigned SURFACE_V  = 32'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic       spawn_dir,
  input  logic [9:0] spawn_v,
  input  logic [9:0] hook_h,
  input  logic [9:0] hook_v,
  input  logic       hook_down,
  output logic [9:0] fish_h_position,
  output logic [9:0] fish_v_position,
  output logic [1:0] fish_way,
  output logic       fish_appear,
  output logic       caught,
  output logic       escaped
);

  fish_state_e state_r;
  fish_state_e state_next_s;
  logic [9:0]  h_next_s;
  logic [9:0]  v_next_s;
  logic [1:0]  way_next_s;
  logic        appear_next_s;
  logic        caught_next_s;
  logic        escaped_next_s;
  logic        hit_s;
  logic [9:0]  swim_v_s;

  fish_hit_detect u_hit (
    .fish_h    (fish_h_position),
    .fish_v    (fish_v_position),
    .hook_h    (hook_h),
    .hook_v    (hook_v),
    .hook_down (hook_down),
    .hit       (hit_s)
  );

`ifdef FISH_MOTION_WOBBLE_EN
  logic [2:0] wob_cnt_r;
  logic       wob_up_r;
  logic [9:0] base_v_r;
  logic       swim_step_s;

  assign swim_step_s = (state_r == ST_SWIM) && frame_tick && !hit_s;

  // Wobble counter: restarts on spawn, flips the offset every eighth swim tick
  always_ff @(posedge clk) begin
    if (rst) begin
      wob_cnt_r <= 3'd0;
      wob_up_r  <= 1'b0;
      base_v_r  <= 10'd0;
    end else if ((state_r == ST_IDLE) && spawn) begin
      wob_cnt_r <= 3'd0;
      wob_up_r  <= 1'b0;
      base_v_r  <= spawn_v;
    end else if (swim_step_s) begin
      wob_cnt_r <= wob_cnt_r + 3'd1;
      wob_up_r  <= (wob_cnt_r == 3'd7) ? ~wob_up_r : wob_up_r;
    end else begin
      wob_cnt_r <= wob_cnt_r;
    end
  end

  // Offset toggles to +1 first, then -1, around the spawn row
  always_comb begin
    if (wob_cnt_r == 3'd7) begin
      swim_v_s = wob_up_r ? (base_v_r - 10'd1) : (base_v_r + 10'd1);
    end else begin
      swim_v_s = fish_v_position;
    end
  end
`else
  assign swim_v_s = fish_v_position;
`endif

  // Next-state and next-output decode; everything holds unless a spawn or tick acts
  always_comb begin
    state_next_s   = state_r;
    h_next_s       = fish_h_position;
    v_next_s       = fish_v_position;
    way_next_s     = fish_way;
    appear_next_s  = fish_appear;
    caught_next_s  = 1'b0;
    escaped_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (spawn) begin
          state_next_s  = ST_SWIM;
          v_next_s      = spawn_v;
          way_next_s    = spawn_dir ? WAY_RIGHT : WAY_LEFT;
          h_next_s      = spawn_dir ? 10'd0 : SPAWN_H_LEFT;
          appear_next_s = 1'b1;
        end else begin
          appear_next_s = 1'b0;
        end
      end
      ST_SWIM: begin
        if (!frame_tick) begin
          state_next_s = ST_SWIM;
        end else if (hit_s) begin
          state_next_s = ST_LIFT;
          way_next_s   = WAY_UP;
          h_next_s     = hook_h + 10'd16;
          v_next_s     = hook_v;
        end else if (fish_way == WAY_RIGHT) begin
          if (({1'b0, fish_h_position} + 11'(SPEED)) >= {1'b0, SPAWN_H_LEFT}) begin
            state_next_s   = ST_IDLE;
            appear_next_s  = 1'b0;
            escaped_next_s = 1'b1;
          end else begin
            h_next_s = fish_h_position + 10'(SPEED);
            v_next_s = swim_v_s;
          end
        end else begin
          if (fish_h_position <= 10'(SPEED)) begin
            state_next_s   = ST_IDLE;
            appear_next_s  = 1'b0;
            escaped_next_s = 1'b1;
          end else begin
            h_next_s = fish_h_position - 10'(SPEED);
            v_next_s = swim_v_s;
          end
        end
      end
      ST_LIFT: begin
        if (!frame_tick) begin
          state_next_s = ST_LIFT;
        end else if (!hook_down) begin
          state_next_s   = ST_IDLE;
          appear_next_s  = 1'b0;
          escaped_next_s = 1'b1;
        end else if ({1'b0, fish_v_position} <= 11'(SURFACE_V + RISE_SPEED)) begin
          state_next_s  = ST_IDLE;
          v_next_s      = 10'(SURFACE_V);
          appear_next_s = 1'b0;
          caught_next_s = 1'b1;
        end else begin
          v_next_s = fish_v_position - 10'(RISE_SPEED);
        end
      end
      default: begin
        state_next_s  = ST_IDLE;
        appear_next_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      fish_h_position <= 10'd0;
      fish_v_position <= 10'd0;
      fish_way        <= WAY_LEFT;
      fish_appear     <= 1'b0;
      caught          <= 1'b0;
      escaped         <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      fish_h_position <= h_next_s;
      fish_v_position <= v_next_s;
      fish_way        <= way_next_s;
      fish_appear     <= appear_next_s;
      caught          <= caught_next_s;
      escaped         <= escaped_next_s;
    end
  end

endmodule
